// File: rtl/key_sample_ctrl.sv
// key_sample_ctrl
//   Multi-key button front end: 2-flop synchronisers, a shared sample-tick
//   prescaler, a per-key shift history with hysteresis, and a per-key FSM that
//   emits one-cycle press/release pulses.
//   Optional feature macro: KEY_SAMPLE_CTRL_AUTOREPEAT_EN adds hold-to-repeat
//   (REPEAT state plus a saturating repeat counter per key).
module key_sample_ctrl #(
    parameter int NUM_KEYS     = 4,
    parameter int SAMPLE_DIV   = 450000,
    parameter int DEPTH        = 10,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                CLK,
    input  logic                NRST,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic                sample_tick,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int               CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_t;

    // Reject parameter sets the datapath cannot represent (history slice needs DEPTH >= 2).
    if (NUM_KEYS < 1 || SAMPLE_DIV < 1 || DEPTH < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("key_sample_ctrl: illegal parameter value");
    end

`ifdef KEY_SAMPLE_CTRL_AUTOREPEAT_EN
    localparam int               RPT_MAX        = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int               RPT_W          = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
    localparam logic [RPT_W-1:0] RPT_SAT        = RPT_W'(RPT_MAX);
`endif

    // ------------------------------------------------------------------
    // Prescaler. The tick is registered so it reads 0 during reset even
    // when SAMPLE_DIV is 1; it is high exactly while the count is last.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] div_cnt_reg;
    logic [CNT_W-1:0] div_cnt_next;
    logic             tick_reg;

    // Wrap the divider count at SAMPLE_DIV-1.
    always_comb begin
        div_cnt_next = (div_cnt_reg == CNT_LAST) ? '0 : div_cnt_reg + 1'b1;
    end

    // Divider count and registered tick strobe.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            tick_reg    <= (div_cnt_next == CNT_LAST);
        end
    end

    assign sample_tick = tick_reg;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the raw pins.
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync1_reg;
    logic [NUM_KEYS-1:0] sync2_reg;

    // Bring the asynchronous key levels into the clock domain.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Per-key history and event FSM; keys are fully independent.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        logic [DEPTH-1:0] hist_reg;
        logic [DEPTH-1:0] hist_new;
        logic             settled_one;
        logic             settled_zero;
        key_state_t       state_reg;
        key_state_t       state_next;
        logic             press_reg;
        logic             press_next;
        logic             release_reg;
        logic             release_next;

        // Decisions are taken on the history as it will look after this tick.
        assign hist_new     = {hist_reg[DEPTH-2:0], sync2_reg[gi]};
        assign settled_one  = &hist_new;
        assign settled_zero = ~|hist_new;

        // Shift the synchronised level into the history once per tick.
        always_ff @(posedge CLK or negedge NRST) begin
            if (!NRST) begin
                hist_reg <= '0;
            end else if (tick_reg) begin
                hist_reg <= hist_new;
            end
        end

`ifdef KEY_SAMPLE_CTRL_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_cnt_reg;
        logic [RPT_W-1:0] rpt_cnt_next;

        // Next state with auto-repeat; a release always wins over a due repeat.
        always_comb begin
            state_next   = state_reg;
            rpt_cnt_next = rpt_cnt_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
            if (tick_reg) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (settled_one) begin
                            state_next   = ST_HELD;
                            press_next   = 1'b1;
                            rpt_cnt_next = '0;
                        end
                    end
                    ST_HELD: begin
                        if (settled_zero) begin
                            state_next   = ST_IDLE;
                            release_next = 1'b1;
                        end else if (rpt_cnt_reg == RPT_DELAY_LAST) begin
                            state_next   = ST_REPEAT;
                            press_next   = 1'b1;
                            rpt_cnt_next = '0;
                        end else if (rpt_cnt_reg != RPT_SAT) begin
                            rpt_cnt_next = rpt_cnt_reg + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (settled_zero) begin
                            state_next   = ST_IDLE;
                            release_next = 1'b1;
                        end else if (rpt_cnt_reg == RPT_RATE_LAST) begin
                            press_next   = 1'b1;
                            rpt_cnt_next = '0;
                        end else if (rpt_cnt_reg != RPT_SAT) begin
                            rpt_cnt_next = rpt_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end
        end

        // Repeat counter register.
        always_ff @(posedge CLK or negedge NRST) begin
            if (!NRST) begin
                rpt_cnt_reg <= '0;
            end else begin
                rpt_cnt_reg <= rpt_cnt_next;
            end
        end
`else
        // Next state without auto-repeat: one press per settled press.
        always_comb begin
            state_next   = state_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
            if (tick_reg) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (settled_one) begin
                            state_next = ST_HELD;
                            press_next = 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (settled_zero) begin
                            state_next   = ST_IDLE;
                            release_next = 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end
        end
`endif

        // State and registered one-cycle event pulses.
        always_ff @(posedge CLK or negedge NRST) begin
            if (!NRST) begin
                state_reg   <= ST_IDLE;
                press_reg   <= 1'b0;
                release_reg <= 1'b0;
            end else begin
                state_reg   <= state_next;
                press_reg   <= press_next;
                release_reg <= release_next;
            end
        end

        assign key_level[gi]   = (state_reg != ST_IDLE);
        assign key_press[gi]   = press_reg;
        assign key_release[gi] = release_reg;
    end

endmodule

// File: tb/tb_key_sample_ctrl.sv
// tb_key_sample_ctrl
//   Table of per-tick key vectors with hand-derived expectations, pushed to a
//   scoreboard when driven and popped by a monitor in the cycle after each tick.
//   Hand-written sequences cover hold-to-repeat and reset in the middle of a hold.
module tb_key_sample_ctrl;

    localparam int NK  = 2;
    localparam int DIV = 4;
    localparam int DEP = 4;
    localparam int RD  = 3;
    localparam int RR  = 2;

`ifdef KEY_SAMPLE_CTRL_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam logic [1:0] ARP0  = AR ? 2'b01 : 2'b00;
    localparam logic [1:0] ARP01 = AR ? 2'b11 : 2'b00;

    logic          CLK;
    logic          NRST;
    logic [NK-1:0] key_in;
    logic          sample_tick;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    key_sample_ctrl #(
        .NUM_KEYS     (NK),
        .SAMPLE_DIV   (DIV),
        .DEPTH        (DEP),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .CLK         (CLK),
        .NRST        (NRST),
        .key_in      (key_in),
        .sample_tick (sample_tick),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    typedef struct packed {
        logic [1:0] keys;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] level;
    } vec_t;

    typedef struct packed {
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] level;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[32];
    int   n_vec = 0;
    int   n_err = 0;
    int   tick_no = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [1:0] k, input logic [1:0] p,
                                input logic [1:0] r, input logic [1:0] l);
        vec_t v;
        v.keys  = k;
        v.press = p;
        v.rel   = r;
        v.level = l;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Wait for the next tick, then return just after the negedge of the
    // following cycle (where the monitor has already checked the events).
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!sample_tick && n < 4 * DIV + 4);
        if (!sample_tick) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout: got no sample_tick, expected one within %0d cycles", 4 * DIV + 4);
        end
        @(negedge CLK);
        #1;
    endtask

    // Drive one sample's worth of key levels and queue its expected events.
    task automatic apply(input logic [1:0] k, input logic [1:0] p,
                         input logic [1:0] r, input logic [1:0] l);
        exp_t e;
        key_in  = k;
        e.press = p;
        e.rel   = r;
        e.level = l;
        sb_q.push_back(e);
        wait_tick();
    endtask

    // Monitor: checks tick spacing, checks events in the cycle after a tick
    // against the scoreboard, and requires silence in every other cycle.
    logic tick_prev = 1'b0;
    int   gap = 0;
    bit   gap_valid = 1'b0;
    exp_t mon_e;
    always @(negedge CLK) begin
        if (!NRST) begin
            tick_prev = 1'b0;
            gap_valid = 1'b0;
            gap       = 0;
        end else begin
            gap++;
            if (tick_prev) begin
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    tick_no++;
                    $display("tick %0d: press=%b release=%b level=%b (want %b %b %b)", tick_no,
                             key_press, key_release, key_level, mon_e.press, mon_e.rel, mon_e.level);
                    check("press", int'(key_press), int'(mon_e.press));
                    check("release", int'(key_release), int'(mon_e.rel));
                    check("level", int'(key_level), int'(mon_e.level));
                end else begin
                    check("idle_press", int'(key_press), 0);
                    check("idle_release", int'(key_release), 0);
                end
            end else begin
                check("offtick_events", int'({key_press, key_release}), 0);
            end
            if (sample_tick) begin
                if (gap_valid) check("tick_gap", gap, DIV);
                gap_valid = 1'b1;
                gap       = 0;
            end
            tick_prev = sample_tick;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Per-tick table: each row is the level sampled at one tick and the
        // events/level expected in the cycle after that tick.
        // Clean press and release of key 0 (repeat due 3 ticks after settle).
        tbl[0]  = mk(2'b01, 2'b00, 2'b00, 2'b00);
        tbl[1]  = mk(2'b01, 2'b00, 2'b00, 2'b00);
        tbl[2]  = mk(2'b01, 2'b00, 2'b00, 2'b00);
        tbl[3]  = mk(2'b01, 2'b01, 2'b00, 2'b01);
        tbl[4]  = mk(2'b00, 2'b00, 2'b00, 2'b01);
        tbl[5]  = mk(2'b00, 2'b00, 2'b00, 2'b01);
        tbl[6]  = mk(2'b00, ARP0,  2'b00, 2'b01);
        tbl[7]  = mk(2'b00, 2'b00, 2'b01, 2'b00);
        // Bounce on key 0, then settle.
        tbl[8]  = mk(2'b01, 2'b00, 2'b00, 2'b00);
        tbl[9]  = mk(2'b00, 2'b00, 2'b00, 2'b00);
        tbl[10] = mk(2'b01, 2'b00, 2'b00, 2'b00);
        tbl[11] = mk(2'b00, 2'b00, 2'b00, 2'b00);
        tbl[12] = mk(2'b01, 2'b00, 2'b00, 2'b00);
        tbl[13] = mk(2'b01, 2'b00, 2'b00, 2'b00);
        tbl[14] = mk(2'b01, 2'b00, 2'b00, 2'b00);
        tbl[15] = mk(2'b01, 2'b01, 2'b00, 2'b01);
        tbl[16] = mk(2'b00, 2'b00, 2'b00, 2'b01);
        tbl[17] = mk(2'b00, 2'b00, 2'b00, 2'b01);
        tbl[18] = mk(2'b00, ARP0,  2'b00, 2'b01);
        tbl[19] = mk(2'b00, 2'b00, 2'b01, 2'b00);
        // Both keys together, then key 1 released alone.
        tbl[20] = mk(2'b11, 2'b00, 2'b00, 2'b00);
        tbl[21] = mk(2'b11, 2'b00, 2'b00, 2'b00);
        tbl[22] = mk(2'b11, 2'b00, 2'b00, 2'b00);
        tbl[23] = mk(2'b11, 2'b11, 2'b00, 2'b11);
        tbl[24] = mk(2'b01, 2'b00, 2'b00, 2'b11);
        tbl[25] = mk(2'b01, 2'b00, 2'b00, 2'b11);
        tbl[26] = mk(2'b01, ARP01, 2'b00, 2'b11);
        tbl[27] = mk(2'b01, 2'b00, 2'b10, 2'b01);
        tbl[28] = mk(2'b00, ARP0,  2'b00, 2'b01);
        tbl[29] = mk(2'b00, 2'b00, 2'b00, 2'b01);
        tbl[30] = mk(2'b00, ARP0,  2'b00, 2'b01);
        tbl[31] = mk(2'b00, 2'b00, 2'b01, 2'b00);

        NRST   = 1'b0;
        key_in = '0;
        repeat (3) @(negedge CLK);
        check("rst_tick", int'(sample_tick), 0);
        check("rst_level", int'(key_level), 0);
        check("rst_press", int'(key_press), 0);
        check("rst_release", int'(key_release), 0);
        #1 NRST = 1'b1;

        // Idle after reset: ticks run, nothing else moves.
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("idle_level", int'(key_level), 0);
        end

        wait_tick();
        for (int i = 0; i < 32; i++) begin
            apply(tbl[i].keys, tbl[i].press, tbl[i].rel, tbl[i].level);
        end

        // Long hold on key 0: settle at sample 3, repeats at 6, 8, ... 20;
        // release settles at 22 where a repeat is also due, so only release fires.
        for (int j = 0; j <= 22; j++) begin
            apply((j <= 18) ? 2'b01 : 2'b00,
                  ((j == 3) || (AR && j >= 6 && j <= 20 && (j % 2) == 0)) ? 2'b01 : 2'b00,
                  (j == 22) ? 2'b01 : 2'b00,
                  (j >= 3 && j < 22) ? 2'b01 : 2'b00);
        end

        // Reset while key 0 is held with the repeat counter at 2.
        for (int j = 0; j < 6; j++) begin
            apply(2'b01, (j == 3) ? 2'b01 : 2'b00, 2'b00, (j >= 3) ? 2'b01 : 2'b00);
        end
        NRST = 1'b0;
        #1;
        check("midrst_level", int'(key_level), 0);
        check("midrst_press", int'(key_press), 0);
        check("midrst_release", int'(key_release), 0);
        check("midrst_tick", int'(sample_tick), 0);
        repeat (2) @(negedge CLK);
        check("midrst_level_hold", int'(key_level), 0);
        #1 NRST = 1'b1;
        // Still-held key re-presses only after four fresh samples, no release.
        for (int j = 0; j < 8; j++) begin
            apply((j < 4) ? 2'b01 : 2'b00,
                  ((j == 3) || (AR && j == 6)) ? 2'b01 : 2'b00,
                  (j == 7) ? 2'b01 : 2'b00,
                  (j >= 3 && j < 7) ? 2'b01 : 2'b00);
        end

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
